// File: rtl/sync_bus_filt.sv
// sync_bus_filt: N-channel pointer synchronizer with an optional stability filter.
// Define SYNC_GRAY_DECODE_EN to decode Gray inputs and flag multi-bit jumps.
module sync_bus_filt #(
  parameter int ADDRSIZE = 8,
  parameter int STAGES   = 2,
  parameter int CHANNELS = 1,
  parameter int FILTER   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*ADDRSIZE-1:0] in_ptr,
  output logic [CHANNELS*ADDRSIZE-1:0] sync_ptr,
  output logic [CHANNELS-1:0]          chg_pulse,
  output logic [CHANNELS-1:0]          stable,
  output logic [CHANNELS-1:0]          gray_err
);

  localparam int AW = ADDRSIZE;

`ifdef SYNC_GRAY_DECODE_EN
  function automatic logic [AW-1:0] g2b(input logic [AW-1:0] g);
    logic [AW-1:0] b;
    b[AW-1] = g[AW-1];
    for (int i = AW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [STAGES-1:0][AW-1:0] s_q;
    logic [AW-1:0]             last;
    logic [AW-1:0]             prev;
    logic [AW-1:0]             cur;
    logic [AW-1:0]             nxt;
    logic                      chg_q;
    logic                      stb_q;

    assign last = s_q[STAGES-1];
    assign prev = s_q[STAGES-2];

    always_ff @(posedge clk) begin
      if (rst) begin
        s_q   <= '0;
        chg_q <= 1'b0;
        stb_q <= 1'b0;
      end else begin
        s_q   <= {s_q[STAGES-2:0], in_ptr[c*AW +: AW]};
        chg_q <= (nxt != cur);
        stb_q <= (cur == last) && (last == prev);
      end
    end

    // cur is the value shown now, nxt the value shown after this edge
    if (FILTER == 0) begin : g_bypass
      assign cur = last;
      assign nxt = prev;
    end else begin : g_filt
      localparam logic [3:0] CNT_MAX = 4'(FILTER);
      localparam logic [3:0] CNT_HIT = 4'(FILTER - 1);

      logic [AW-1:0] cand_q;
      logic [AW-1:0] cand_d;
      logic [AW-1:0] sync_q;
      logic [AW-1:0] sync_d;
      logic [3:0]    cnt_q;
      logic [3:0]    cnt_d;

      always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        sync_d = sync_q;
        if (last != cand_q) begin
          cand_d = last;
          cnt_d  = '0;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
          end
          if (cnt_q == CNT_HIT) begin
            sync_d = cand_q;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cand_q <= '0;
          cnt_q  <= '0;
          sync_q <= '0;
        end else begin
          cand_q <= cand_d;
          cnt_q  <= cnt_d;
          sync_q <= sync_d;
        end
      end

      assign cur = sync_q;
      assign nxt = sync_d;
    end

`ifdef SYNC_GRAY_DECODE_EN
    logic [AW-1:0] diff;
    logic          err_q;

    assign diff = nxt ^ cur;

    // more than one bit set: clearing the lowest set bit leaves something
    always_ff @(posedge clk) begin
      if (rst) begin
        err_q <= 1'b0;
      end else begin
        err_q <= |(diff & (diff - AW'(1)));
      end
    end

    assign sync_ptr[c*AW +: AW] = g2b(cur);
    assign gray_err[c]          = err_q;
`else
    assign sync_ptr[c*AW +: AW] = cur;
    assign gray_err[c]          = 1'b0;
`endif

    assign chg_pulse[c] = chg_q;
    assign stable[c]    = stb_q;
  end

endmodule

// File: tb/tb_sync_bus_filt.sv
// tb_sync_bus_filt: directed checks of sync_bus_filt in a filtered
// two-channel build and a three-stage bypass build.
module tb_sync_bus_filt;

`ifdef SYNC_GRAY_DECODE_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_a;
  logic [7:0] sync_a;
  logic [1:0] chg_a;
  logic [1:0] stb_a;
  logic [1:0] err_a;
  logic [7:0] in_b;
  logic [7:0] sync_b;
  logic [0:0] chg_b;
  logic [0:0] stb_b;
  logic [0:0] err_b;

  int n_chk  = 0;
  int n_fail = 0;

  sync_bus_filt #(
    .ADDRSIZE(4),
    .STAGES  (2),
    .CHANNELS(2),
    .FILTER  (3)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .in_ptr   (in_a),
    .sync_ptr (sync_a),
    .chg_pulse(chg_a),
    .stable   (stb_a),
    .gray_err (err_a)
  );

  sync_bus_filt #(
    .ADDRSIZE(8),
    .STAGES  (3),
    .CHANNELS(1),
    .FILTER  (0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_ptr   (in_b),
    .sync_ptr (sync_b),
    .chg_pulse(chg_b),
    .stable   (stb_b),
    .gray_err (err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [7:0] e8(input logic [7:0] v);
    return GRAY ? g2b(v) : v;
  endfunction

  function automatic logic [3:0] e4(input logic [3:0] v);
    logic [7:0] t;
    t = e8({4'h0, v});
    return t[3:0];
  endfunction

  function automatic bit mb(input logic [7:0] a, input logic [7:0] b);
    return $countones(a ^ b) > 1;
  endfunction

  // ch0 moves from a settled value to a new one; ch1 sits at 0
  task automatic step_a(input logic [3:0] from, input logic [3:0] to);
    logic [3:0] sv;
    in_a = {4'h0, to};
    for (int i = 1; i <= 7; i++) begin
      tick();
      sv = (i >= 6) ? e4(to) : e4(from);
      chk("a_sync", sync_a, {4'h0, sv});
      chk("a_chg", chg_a, {1'b0, i == 6 && from != to});
      chk("a_stb", stb_a, {1'b1, from == to || i < 2 || i > 6});
      chk("a_err", err_a, {1'b0, GRAY && i == 6 && mb(from, to)});
    end
  endtask

  logic [7:0] bb_in [3] = '{8'h01, 8'h02, 8'h03};
  logic [7:0] bb_exp[6] = '{8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h03};
  bit         bb_chg[6] = '{0, 0, 1, 1, 1, 0};
  bit         bb_stb[6] = '{1, 1, 0, 0, 0, 1};
  bit         bb_err[6] = '{0, 0, 1, 1, 0, 0};

  initial begin
    rst  = 1'b1;
    in_a = 8'hFF;
    in_b = 8'hFF;
    tick();
    tick();
    chk("rst_sync_a", sync_a, 8'h00);
    chk("rst_chg_a", chg_a, 2'b00);
    chk("rst_stb_a", stb_a, 2'b00);
    chk("rst_err_a", err_a, 2'b00);
    chk("rst_sync_b", sync_b, 8'h00);
    chk("rst_chg_b", chg_b, 1'b0);
    chk("rst_stb_b", stb_b, 1'b0);
    chk("rst_err_b", err_b, 1'b0);

    rst  = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    tick();
    chk("rel_stb_a", stb_a, 2'b11);
    chk("rel_stb_b", stb_b, 1'b1);
    chk("rel_chg_a", chg_a, 2'b00);

    in_b = 8'hA5;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("b_sync", sync_b, (i >= 3) ? e8(8'hA5) : 8'h00);
      chk("b_chg", chg_b, i == 3);
      chk("b_stb", stb_b, i != 3);
      chk("b_err", err_b, GRAY && i == 3 && mb(8'h00, 8'hA5));
    end

    for (int i = 0; i < 6; i++) begin
      in_b = (i < 3) ? bb_in[i] : 8'h03;
      tick();
      chk("bb_sync", sync_b, e8(bb_exp[i]));
      chk("bb_chg", chg_b, bb_chg[i]);
      chk("bb_stb", stb_b, bb_stb[i]);
      chk("bb_err", err_b, GRAY && bb_err[i]);
    end

    step_a(4'h0, 4'h5);

    for (int i = 1; i <= 8; i++) begin
      in_a = {(i <= 3) ? 4'h9 : 4'h0, 4'h5};
      tick();
      chk("g3_sync", sync_a, {4'h0, e4(4'h5)});
      chk("g3_chg", chg_a, 2'b00);
      chk("g3_stb", stb_a, {!(i >= 2 && i <= 5), 1'b1});
      chk("g3_err", err_a, 2'b00);
    end

    for (int i = 1; i <= 12; i++) begin
      in_a = {(i <= 4) ? 4'h9 : 4'h0, 4'h5};
      tick();
      chk("g4_sync", sync_a,
          {(i >= 6 && i <= 9) ? e4(4'h9) : 4'h0, e4(4'h5)});
      chk("g4_chg", chg_a, {i == 6 || i == 10, 1'b0});
      chk("g4_stb", stb_a, {!(i >= 2 && i <= 10), 1'b1});
      chk("g4_err", err_a, {GRAY && (i == 6 || i == 10), 1'b0});
    end

    in_a = 8'h07;
    tick();
    rst = 1'b1;
    tick();
    chk("mo_sync", sync_a, 8'h00);
    chk("mo_chg", chg_a, 2'b00);
    chk("mo_stb", stb_a, 2'b00);
    chk("mo_err", err_a, 2'b00);
    chk("mo_sync_b", sync_b, 8'h00);

    rst  = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("mo_drop_sync", sync_a, 8'h00);
      chk("mo_drop_chg", chg_a, 2'b00);
      chk("mo_drop_stb", stb_a, 2'b11);
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    step_a(4'h0, 4'h7);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    step_a(4'h0, 4'h1);
    step_a(4'h1, 4'h3);
    step_a(4'h3, 4'h5);
    step_a(4'h5, 4'hF);
    step_a(4'hF, 4'h0);
    step_a(4'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_bus_filt.md
Name: sync_bus_filt

Overview:
- Parametrised multi-channel, multi-stage pointer synchronizer for the destination clock domain. It is the next generation of the team's dual-flop pointer synchronizer.
- Adds the following over a plain flop chain:
  - configurable chain depth;
  - N independent channels;
  - optional stability (glitch) filter;
  - per-channel change pulse and stable flag;
  - optional Gray decode with multi-bit-jump detection.
- Sits at the async FIFO read and write sides, and wherever status words cross domains.

Parameters:
- ADDRSIZE, 8, width of each channel's pointer.
- STAGES, 2, synchronizer flop-chain depth; legal range 2..4.
- CHANNELS, 1, number of independent pointer channels.
- FILTER, 0, stability count F. 0 means filter bypassed; legal range 0..15.

Ports:
- clk  input  1  destination-domain clock
- rst  input  1  reset, synchronous, active-high
- in_ptr  input  CHANNELS*ADDRSIZE  asynchronous pointers; channel c is bits [c*ADDRSIZE +: ADDRSIZE]
- sync_ptr  output  CHANNELS*ADDRSIZE  synchronized (and filtered) pointers, same packing
- chg_pulse  output  CHANNELS  one-cycle pulse per channel when sync_ptr changes value
- stable  output  CHANNELS  per channel, no change in flight
- gray_err  output  CHANNELS  one-cycle pulse on a non-Gray jump; tied 0 without the macro

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. All state clears on the clk edge where rst=1.
- Reset values: every chain stage, cand, cnt, sync_ptr, chg_pulse, stable and gray_err are 0. in_ptr is ignored while rst=1.
- Channels are fully independent. Any combination may change on the same edge.
- Chain: each channel has flops s[1..STAGES] per edge, with s[1]<=in_ptr and s[k]<=s[k-1]. Call s_last = s[STAGES].
- FILTER=0:
  - sync_ptr = s_last, driven directly from the register.
  - Latency is STAGES edges from the first edge that samples the new input.
- FILTER=F>0, per channel, using registers cand (ADDRSIZE bits) and cnt (saturating at F). Each edge:
  - if s_last != cand: cand<=s_last, cnt<=0;
  - else if cnt != F: cnt<=cnt+1.
  - If s_last==cand and cnt==F-1, then sync_ptr<=cand on that same edge.
- Filter result:
  - A value held on in_ptr for at least F+1 consecutive sampled edges appears on sync_ptr.
  - Latency is STAGES+F+1 edges.
  - A value held for fewer than F+1 sampled edges never appears on sync_ptr.
- chg_pulse[c]:
  - Registered, and high for exactly one cycle, coincident with the first cycle sync_ptr[c] shows a new value.
  - Loading an equal value produces no pulse.
- stable[c]:
  - Registered, high when sync_ptr[c]==s_last and s_last==s[STAGES-1].
  - Low whenever a differing value is in the last two stages or pending in the filter.
  - Goes high on the first edge after reset release when inputs are 0.
- Reset mid-operation: in-flight and filtered values are discarded and all outputs return to 0 next edge. No chg_pulse is generated by the reset itself.
- Wrap-around: no arithmetic on pointer values. An all-ones to 0 transition is an ordinary change.

Optional Feature:
- Macro name: SYNC_GRAY_DECODE_EN.
- With the macro defined:
  - in_ptr is treated as Gray code.
  - sync_ptr outputs the binary decode of the internal synchronized/filtered Gray value; the decode is combinational after the sync register, so latency is unchanged.
  - chg_pulse and stable are computed on the Gray value.
  - gray_err[c] pulses for one cycle, coincident with chg_pulse, when the new Gray value differs from the previous one in more than one bit.
- Without the macro:
  - sync_ptr is the raw value and gray_err is constant 0.
  - No decode logic is present.

Test Plan:
- Reset (ADDRSIZE=4, STAGES=2, F=3, CHANNELS=2): rst=1 for 2 edges with in_ptr=0xFF -> sync_ptr=0, chg_pulse=0, stable=0, gray_err=0. Release rst -> stable=2'b11 after 1 edge.
- Step (same config): in_ptr ch0 0->5, held -> sync_ptr ch0=5 exactly 6 edges after the first sampling edge. chg_pulse[0] high for that one cycle. stable[0] is low in between. ch1 is unaffected.
- Glitch (same config): ch1 0->9 for 3 sampled edges, then back to 0 -> sync_ptr ch1 stays 0 and chg_pulse[1] never asserts. stable[1] dips low, then returns high. Repeat holding 9 for 4 edges -> 9 appears.
- Bypass (STAGES=3, F=0): in_ptr 0->0xA5 -> sync_ptr=0xA5 after 3 edges, with chg_pulse coincident. Back-to-back changes on consecutive edges each appear 3 edges later, each with a pulse.
- Mid-op reset: assert rst one edge after ch0 value 7 enters the chain -> all outputs 0 next edge. Value 7 never appears unless it is still driven after release.
- Gray (macro on, ADDRSIZE=4): Gray 0000->0001->0011 -> sync_ptr binary 0, 1, 2 with gray_err=0. Jump 0011->0101 -> sync_ptr=6 (binary) and gray_err pulses one cycle with chg_pulse.
